// File: rtl/lz77_encoder.sv
// LZ77 encoder, 9-symbol search window and 8-symbol lookahead; one codeword per 9-cycle sweep plus 1 emit cycle.
// No output backpressure. in_ready is low except while the lookahead is filling and no '$' is buffered.
module lz77_encoder (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] chardata,
    output logic       in_ready,
    output logic       valid,
    output logic [3:0] code_pos,
    output logic [2:0] code_len,
    output logic [7:0] char_nxt,
    output logic       encode,
    output logic       finish
);
    localparam logic [7:0] END_SYM = 8'h24;

    typedef enum logic [1:0] {FILL, SEARCH, EMIT, DONE} state_t;
    state_t state, state_nxt;

    logic [7:0] sb     [0:8];
    logic [7:0] la     [0:7];
    logic [7:0] sb_nxt [0:8];
    logic [7:0] la_nxt [0:7];
    logic [3:0] sb_cnt, la_cnt;
    logic       seen_end;
    logic [3:0] cand;
    logic [3:0] best_pos, best_pos_n;
    logic [2:0] best_len, best_len_n;
    logic [2:0] cand_len;
    logic [3:0] n_used;
    logic [4:0] sb_sum;
    logic       accept;

    assign in_ready = encode && (state == FILL) && (la_cnt < 4'd8) && !seen_end;
    assign accept   = in_valid && in_ready;

    // Match length of the current candidate; positions past p read from the lookahead itself.
    always_comb begin
        logic [2:0] cap;
        logic       run;
        logic [7:0] ref_sym;
        logic [3:0] sb_idx;
        logic [2:0] la_idx;
        logic [2:0] len_acc;
        cap     = (la_cnt == 4'd0) ? 3'd0 : (la_cnt >= 4'd8) ? 3'd7 : 3'(la_cnt - 4'd1);
        run     = 1'b1;
        ref_sym = 8'h00;
        sb_idx  = 4'd0;
        la_idx  = 3'd0;
        len_acc = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) <= cand) begin
                sb_idx  = cand - 4'(i);
                ref_sym = sb[sb_idx];
            end else begin
                la_idx  = 3'(4'(i) - cand - 4'd1);
                ref_sym = la[la_idx];
            end
            if (run && (4'(i) < {1'b0, cap}) && (la[3'(i)] == ref_sym))
                len_acc = len_acc + 3'd1;
            else
                run = 1'b0;
        end
        cand_len = (cand < sb_cnt) ? len_acc : 3'd0;
    end

    // Strict compare keeps the smallest position on ties.
    assign best_pos_n = (cand_len > best_len) ? cand : best_pos;
    assign best_len_n = (cand_len > best_len) ? cand_len : best_len;

    assign n_used = {1'b0, code_len} + 4'd1;
    assign sb_sum = {1'b0, sb_cnt} + {1'b0, n_used};

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            if (4'(k) < n_used)
                sb_nxt[k] = la[3'(n_used - 4'(k) - 4'd1)];
            else
                sb_nxt[k] = sb[4'(k) - n_used];
        end
        for (int j = 0; j < 8; j++) begin
            if ((4'(j) + n_used) < 4'd8)
                la_nxt[j] = la[3'(4'(j) + n_used)];
            else
                la_nxt[j] = 8'h00;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (la_cnt == 4'd8 || seen_end) state_nxt = SEARCH;
            SEARCH:  if (cand == 4'd8) state_nxt = EMIT;
            EMIT:    state_nxt = (char_nxt == END_SYM) ? DONE : FILL;
            default: state_nxt = DONE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= FILL;
            sb_cnt   <= 4'd0;
            la_cnt   <= 4'd0;
            seen_end <= 1'b0;
            cand     <= 4'd0;
            best_pos <= 4'd0;
            best_len <= 3'd0;
            valid    <= 1'b0;
            code_pos <= 4'd0;
            code_len <= 3'd0;
            char_nxt <= 8'h00;
            encode   <= 1'b0;
            finish   <= 1'b0;
            for (int k = 0; k < 9; k++) sb[k] <= 8'h00;
            for (int j = 0; j < 8; j++) la[j] <= 8'h00;
        end else begin
            state <= state_nxt;
            case (state)
                FILL: begin
                    encode <= 1'b1;
                    if (accept) begin
                        la[la_cnt[2:0]] <= chardata;
                        la_cnt          <= la_cnt + 4'd1;
                        if (chardata == END_SYM) seen_end <= 1'b1;
                    end
                    if (state_nxt == SEARCH) begin
                        cand     <= 4'd0;
                        best_pos <= 4'd0;
                        best_len <= 3'd0;
                    end
                end
                SEARCH: begin
                    best_pos <= best_pos_n;
                    best_len <= best_len_n;
                    cand     <= cand + 4'd1;
                    if (cand == 4'd8) begin
                        valid    <= 1'b1;
                        code_pos <= best_pos_n;
                        code_len <= best_len_n;
                        char_nxt <= la[best_len_n];
                    end
                end
                EMIT: begin
                    valid  <= 1'b0;
                    sb     <= sb_nxt;
                    la     <= la_nxt;
                    la_cnt <= la_cnt - n_used;
                    sb_cnt <= (sb_sum > 5'd9) ? 4'd9 : sb_sum[3:0];
                    if (char_nxt == END_SYM) begin
                        finish <= 1'b1;
                        encode <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lz77_encoder.sv
// Directed table-driven bench for lz77_encoder with a reference decoder for round-trip checks.
module tb_lz77_encoder;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] chardata = 8'h00;
    logic       in_ready, valid, encode, finish;
    logic [3:0] code_pos;
    logic [2:0] code_len;
    logic [7:0] char_nxt;

    int checks = 0;
    int errors = 0;

    lz77_encoder dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .chardata(chardata),
        .in_ready(in_ready), .valid(valid), .code_pos(code_pos), .code_len(code_len),
        .char_nxt(char_nxt), .encode(encode), .finish(finish)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n_in;
        logic [7:0] msg [12];
        bit         toggle;
        int         n_cw;
        logic [3:0] pos [10];
        logic [2:0] len [10];
        logic [7:0] ch  [10];
    } vec_t;

    localparam int NVEC = 6;
    vec_t vt [NVEC];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_vec(input int v, input string s, input bit tg);
        vt[v].n_in   = s.len();
        vt[v].toggle = tg;
        vt[v].n_cw   = 0;
        for (int k = 0; k < s.len(); k++) vt[v].msg[k] = s[k];
    endtask

    task automatic add_cw(input int v, input int p, input int l, input byte c);
        vt[v].pos[vt[v].n_cw] = 4'(p);
        vt[v].len[vt[v].n_cw] = 3'(l);
        vt[v].ch[vt[v].n_cw]  = c;
        vt[v].n_cw++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("reset_outputs", {valid, in_ready, encode, finish, code_pos, code_len, char_nxt}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset_encode", {31'h0, encode}, 32'h1);
        chk("post_reset_in_ready", {31'h0, in_ready}, 32'h1);
    endtask

    task automatic run_vector(input int v);
        logic [3:0] gp [$];
        logic [2:0] gl [$];
        logic [7:0] gc [$];
        logic [7:0] hist [9];
        logic [7:0] dec [$];
        logic [7:0] s;
        int idx, cyc, last_acc, first_lat, bad;
        bit done_seen, timeout, rdy_bad, late_bad;
        idx = 0; cyc = 0; last_acc = -100; first_lat = -1;
        done_seen = 0; timeout = 0; rdy_bad = 0;
        while (!done_seen && !timeout) begin
            @(negedge clk);
            cyc++;
            if (valid) begin
                gp.push_back(code_pos);
                gl.push_back(code_len);
                gc.push_back(char_nxt);
                if (first_lat < 0) first_lat = cyc - last_acc;
                if (in_ready) rdy_bad = 1;
                if (char_nxt == 8'h24) done_seen = 1;
            end
            if (idx < vt[v].n_in && (!vt[v].toggle || (cyc % 2 == 0))) begin
                in_valid = 1'b1;
                chardata = vt[v].msg[idx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready) begin
                idx++;
                last_acc = cyc;
            end
            if (cyc > 2000) timeout = 1;
        end
        in_valid = 1'b0;
        if (timeout) begin
            checks++; errors++;
            $display("FAIL vec%0d_timeout: got no end codeword within 2000 cycles", v);
        end
        chk($sformatf("vec%0d_count", v), gp.size(), vt[v].n_cw);
        for (int k = 0; k < vt[v].n_cw && k < gp.size(); k++)
            chk($sformatf("vec%0d_cw%0d", v, k), {17'h0, gp[k], gl[k], gc[k]},
                {17'h0, vt[v].pos[k], vt[v].len[k], vt[v].ch[k]});
        chk($sformatf("vec%0d_latency", v), first_lat, 11);
        chk($sformatf("vec%0d_rdy_in_emit", v), {31'h0, rdy_bad}, 32'h0);
        @(negedge clk);
        chk($sformatf("vec%0d_finish", v), {valid, encode, finish, in_ready}, 4'b0010);
        // Round trip through a software decoder.
        for (int j = 0; j < 9; j++) hist[j] = 8'h00;
        for (int k = 0; k < gp.size(); k++) begin
            for (int i = 0; i <= int'(gl[k]); i++) begin
                s = (i == int'(gl[k])) ? gc[k] : ((gp[k] < 4'd9) ? hist[gp[k]] : 8'hxx);
                for (int j = 8; j > 0; j--) hist[j] = hist[j-1];
                hist[0] = s;
                dec.push_back(s);
            end
        end
        bad = (dec.size() == vt[v].n_in) ? 0 : 1;
        for (int k = 0; k < dec.size() && k < vt[v].n_in; k++)
            if (dec[k] !== vt[v].msg[k]) bad++;
        chk($sformatf("vec%0d_roundtrip", v), bad, 0);
        // DONE ignores further input.
        late_bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            chardata = 8'h41;
            #1;
            if (valid || in_ready || !finish || encode) late_bad = 1;
        end
        in_valid = 1'b0;
        chk($sformatf("vec%0d_done_hold", v), {31'h0, late_bad}, 32'h0);
    endtask

    initial begin
        int waited;
        set_vec(0, "ABCD$", 0);
        add_cw(0, 0, 0, "A"); add_cw(0, 0, 0, "B"); add_cw(0, 0, 0, "C");
        add_cw(0, 0, 0, "D"); add_cw(0, 0, 0, "$");
        set_vec(1, "AAAAAAAAA$", 0);
        add_cw(1, 0, 0, "A"); add_cw(1, 0, 7, "A"); add_cw(1, 0, 0, "$");
        set_vec(2, "ABABAB$", 0);
        add_cw(2, 0, 0, "A"); add_cw(2, 0, 0, "B"); add_cw(2, 1, 4, "$");
        set_vec(3, "ABABAB$", 1);
        add_cw(3, 0, 0, "A"); add_cw(3, 0, 0, "B"); add_cw(3, 1, 4, "$");
        set_vec(4, "ABCABCABC$", 0);
        add_cw(4, 0, 0, "A"); add_cw(4, 0, 0, "B"); add_cw(4, 0, 0, "C");
        add_cw(4, 2, 6, "$");
        set_vec(5, "ABCDEFGHIA$", 0);
        add_cw(5, 0, 0, "A"); add_cw(5, 0, 0, "B"); add_cw(5, 0, 0, "C");
        add_cw(5, 0, 0, "D"); add_cw(5, 0, 0, "E"); add_cw(5, 0, 0, "F");
        add_cw(5, 0, 0, "G"); add_cw(5, 0, 0, "H"); add_cw(5, 0, 0, "I");
        add_cw(5, 8, 1, "$");

        for (int v = 0; v < NVEC; v++) begin
            do_reset();
            run_vector(v);
        end

        // Abort in the middle of the second search sweep, then encode cleanly.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            chardata = vt[0].msg[k];
        end
        @(negedge clk);
        in_valid = 1'b0;
        waited = 0;
        while (!valid && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("abort_first_cw", {valid, char_nxt}, {1'b1, 8'h41});
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_outputs", {valid, in_ready, encode, finish, code_pos, code_len, char_nxt}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_restart", {encode, in_ready, valid}, 3'b110);
        run_vector(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
